// File: rtl/div_iter.sv
// div_iter: multicycle 32-bit signed/unsigned divider, one restoring step per cycle.
// Returns {remainder, quotient} for the HI/LO write-back of DIV/DIVU.
//
// Handshake: EX raises start_i with operands and holds it until it sees ready_o.
// The operands are taken at the first edge in IDLE with start_i=1 and annul_i=0.
// ready_o is high while the block sits in DONE with a valid result_o. The block
// stays in DONE until start_i drops, and it is back in IDLE one edge later.
// Dropping start_i or raising annul_i before DONE abandons the operation.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Partial remainder in [63:32], quotient bits shift in at [31:0]. The top bit
    // of a 65-bit restoring register is always zero between steps, because the
    // remainder stays below the divisor. The shifted-out bit only matters inside
    // a single step, where it is carried as trial[32].
    logic [63:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] abs_dividend;
    logic [31:0] abs_divisor;
    logic [32:0] trial;
    logic        fits;
    logic [31:0] trial_sub;
    logic [63:0] step;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes; -2^31 negates to itself, which is right as an unsigned magnitude.
    always_comb begin
        abs_dividend = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        abs_divisor  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // One restoring step: shift left, trial-subtract divisor, keep or restore.
    always_comb begin
        trial     = work_q[63:31];
        fits      = (trial >= {1'b0, divisor_q});
        trial_sub = trial[31:0] - divisor_q;
        if (fits) begin
            step = {trial_sub, work_q[30:0], 1'b1};
        end else begin
            step = {work_q[62:0], 1'b0};
        end
        quot_fix = neg_quot_q ? (~step[31:0] + 32'd1) : step[31:0];
        rem_fix  = neg_rem_q ? (~step[63:32] + 32'd1) : step[63:32];
    end

    // Next-state logic for the divider sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    work_d     = {32'd0, abs_dividend};
                    divisor_d  = abs_divisor;
                    cnt_d      = 5'd0;
                    neg_quot_d = signed_div_i && (opdata1_i[31] != opdata2_i[31]);
                    neg_rem_d  = signed_div_i && opdata1_i[31];
                    state_d    = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                if (annul_i || !start_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    ready_d  = 1'b1;
                    result_d = 64'd0;
                end
            end
            S_ON: begin
                if (annul_i || !start_i) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_DONE;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            default: begin
                // DONE: annul_i is ignored, only dropping start_i releases the result.
                if (!start_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            work_q     <= 64'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter. Inputs change on the falling
// edge and outputs are sampled there, half a cycle away from the active edge.
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total;
    int bad;
    int cyc;
    logic [63:0] exp_q[$];

    div_iter dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer division in 64-bit arithmetic, truncating
    // toward zero, results taken mod 2^32; a zero divisor yields zero.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Driver: present a request at a falling edge and wait for ready_o.
    // edges = active edges from acceptance up to and including the one raising ready_o.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int edges, output bit timeout);
        int n;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 100);
        timeout = !ready_o;
        edges   = n - 1;
        res     = result_o;
        // Operand changes after acceptance must not matter.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = $urandom_range(0, 1);
    endtask

    // Driver: drop start_i and sample the outputs one edge later.
    task automatic release_start(output logic rdy, output logic [63:0] res);
        start_i = 1'b0;
        @(negedge clk);
        rdy = ready_o;
        res = result_o;
    endtask

    task automatic test_reset;
        resetn  = 1'b0;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (2) @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_state: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
        end
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL after_reset_idle: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_directed;
        logic [31:0] a_t[8];
        logic [31:0] b_t[8];
        logic        s_t[8];
        logic [63:0] e_t[8];
        logic [63:0] res, exp, rr;
        logic        rdy;
        int edges;
        bit to;
        a_t[0] = 32'd7;          b_t[0] = 32'd2;          s_t[0] = 1'b0; e_t[0] = 64'h00000001_00000003;
        a_t[1] = 32'hFFFFFFF9;   b_t[1] = 32'd2;          s_t[1] = 1'b1; e_t[1] = 64'hFFFFFFFF_FFFFFFFD;
        a_t[2] = 32'd7;          b_t[2] = 32'hFFFFFFFE;   s_t[2] = 1'b1; e_t[2] = 64'h00000001_FFFFFFFD;
        a_t[3] = 32'h80000000;   b_t[3] = 32'hFFFFFFFF;   s_t[3] = 1'b1; e_t[3] = 64'h00000000_80000000;
        a_t[4] = 32'h80000000;   b_t[4] = 32'hFFFFFFFF;   s_t[4] = 1'b0; e_t[4] = 64'h80000000_00000000;
        a_t[5] = 32'h12345678;   b_t[5] = 32'd0;          s_t[5] = 1'b0; e_t[5] = 64'd0;
        a_t[6] = 32'd100;        b_t[6] = 32'd7;          s_t[6] = 1'b1; e_t[6] = 64'h00000002_0000000E;
        a_t[7] = 32'hFFFFFFFF;   b_t[7] = 32'd1;          s_t[7] = 1'b0; e_t[7] = 64'h00000000_FFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(e_t[i]);
            do_div(a_t[i], b_t[i], s_t[i], res, edges, to);
            exp = exp_q.pop_front();
            total++;
            if (to) begin
                bad++;
                $display("FAIL directed_timeout[%0d]: ready never rose within 100 cycles", i);
            end
            total++;
            if (edges !== ((b_t[i] == 32'd0) ? 1 : 32)) begin
                bad++;
                $display("FAIL directed_latency[%0d]: edges=%0d want %0d", i, edges, (b_t[i] == 32'd0) ? 1 : 32);
            end
            total++;
            if (res !== exp) begin
                bad++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, res, exp);
            end
            release_start(rdy, rr);
            total++;
            if (rdy !== 1'b0 || rr !== 64'd0) begin
                bad++;
                $display("FAIL directed_release[%0d]: ready=%b result=%h want 0/0", i, rdy, rr);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic s;
        logic [63:0] res, exp, rr;
        logic rdy;
        int edges;
        bit to;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 20);
                3:       b = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            s = $urandom_range(0, 1);
            exp_q.push_back(model(a, b, s));
            do_div(a, b, s, res, edges, to);
            exp = exp_q.pop_front();
            total++;
            if (to || res !== exp || edges !== ((b == 32'd0) ? 1 : 32)) begin
                bad++;
                $display("FAIL random[%0d] %h/%h s=%b: got %h edges=%0d to=%0d want %h",
                         i, a, b, s, res, edges, to, exp);
            end
            release_start(rdy, rr);
            total++;
            if (rdy !== 1'b0 || rr !== 64'd0) begin
                bad++;
                $display("FAIL random_release[%0d]: ready=%b result=%h want 0/0", i, rdy, rr);
            end
        end
    endtask

    task automatic test_abort(input bit use_annul);
        logic [63:0] res, rr;
        logic rdy;
        int edges;
        int seen;
        bit to;
        opdata1_i    = 32'h12345678;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        // Acceptance edge plus ten steps: the counter reads 10.
        repeat (11) @(negedge clk);
        if (use_annul) begin
            annul_i = 1'b1;
            @(negedge clk);
            annul_i = 1'b0;
        end
        start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || result_o !== 64'd0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_quiet(annul=%0d): outputs nonzero on %0d cycles, want 0", use_annul, seen);
        end
        exp_q.push_back(model(32'd100, 32'd7, 1'b0));
        do_div(32'd100, 32'd7, 1'b0, res, edges, to);
        total++;
        if (to || edges != 32 || res !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL abort_recover(annul=%0d): got %h edges=%0d want 000000020000000e edges=32",
                     use_annul, res, edges);
        end
        release_start(rdy, rr);
    endtask

    task automatic test_reset_mid;
        logic [63:0] res, held, rr;
        logic rdy;
        int edges;
        int bad_hold;
        bit to;
        // Reset during ON, between edges.
        opdata1_i    = 32'hFFFF;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (6) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid_on: ready=%b result=%h want 0/0", ready_o, result_o);
        end
        @(negedge clk);
        resetn  = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        // Reset while DONE holds a result must clear it before any edge.
        do_div(32'd50, 32'd4, 1'b0, res, edges, to);
        #2 resetn = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_async_done: ready=%b result=%h want 0/0", ready_o, result_o);
        end
        @(negedge clk);
        resetn  = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        exp_q.push_back(model(32'd9, 32'd3, 1'b0));
        do_div(32'd9, 32'd3, 1'b0, res, edges, to);
        total++;
        if (to || edges != 32 || res !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL reset_recover: got %h edges=%0d want 0000000000000003 edges=32", res, edges);
        end
        held = 64'h00000000_00000003;
        bad_hold = 0;
        annul_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b1 || result_o !== held) bad_hold++;
        end
        annul_i = 1'b0;
        total++;
        if (bad_hold != 0) begin
            bad++;
            $display("FAIL done_hold: %0d of 5 cycles lost ready/result, last ready=%b result=%h want 1/%h",
                     bad_hold, ready_o, result_o, held);
        end
        release_start(rdy, rr);
        total++;
        if (rdy !== 1'b0 || rr !== 64'd0) begin
            bad++;
            $display("FAIL done_hold_release: ready=%b result=%h want 0/0", rdy, rr);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] res, exp, rr;
        logic rdy;
        int edges;
        int t_prev;
        bit to;
        logic [31:0] a, b;
        t_prev = -1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            exp_q.push_back(model(a, b, 1'b1));
            do_div(a, b, 1'b1, res, edges, to);
            exp = exp_q.pop_front();
            total++;
            if (to || res !== exp) begin
                bad++;
                $display("FAIL b2b_result[%0d]: got %h want %h", i, res, exp);
            end
            if (t_prev >= 0) begin
                total++;
                if (cyc - t_prev != 34) begin
                    bad++;
                    $display("FAIL b2b_gap[%0d]: gap=%0d cycles want 34", i, cyc - t_prev);
                end
            end
            t_prev = cyc;
            release_start(rdy, rr);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset();
        test_directed();
        test_random();
        test_abort(1'b1);
        test_abort(1'b0);
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
